// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 single-wire controller protocol blocks.
package n64_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_BIT  = 3'd1,
    TX_STOP = 3'd2,
    RX_WAIT = 3'd3,
    RX_BIT  = 3'd4,
    DONE    = 3'd5,
    GUARD   = 3'd6
  } state_t;

  localparam logic [7:0] CMD_POLL = 8'h01;

  // Bit-time multipliers in microseconds.
  localparam int T_LONG   = 3;
  localparam int T_SHORT  = 1;
  localparam int T_BIT    = 4;
  localparam int T_SAMPLE = 2;

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchroniser for the raw data_line level plus falling-edge detect.
module n64_line_sync (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic line_in,
  output logic line_s,
  output logic fall_s
);

  logic meta;
  logic line_d;

  // Flops reset to 1 (idle, pulled-up line) so that leaving reset never looks like an edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      meta   <= 1'b1;
      line_s <= 1'b1;
      line_d <= 1'b1;
    end else begin
      meta   <= line_in;
      line_s <= meta;
      line_d <= line_s;
    end
  end

  assign fall_s = line_d & ~line_s;

endmodule

// File: rtl/n64_poll_engine.sv
// N64 poll engine: sends the poll command on the open-drain data_line and
// captures the controller's 32-bit response by pulse-width sampling.
module n64_poll_engine
  import n64_pkg::*;
#(
  parameter int         US_CYCLES             = 100,
  parameter logic [7:0] CMD_BYTE              = CMD_POLL,
  parameter int         RESP_BITS             = 32,
  parameter int         FIRST_EDGE_TIMEOUT_US = 64,
  parameter int         BIT_TIMEOUT_US        = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  input  logic                 poll_start,
  input  logic                 line_in,
  output logic                 line_oe,
  output logic [RESP_BITS-1:0] buttons,
  output logic                 resp_valid,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [2:0]           monitor_sig
);

  localparam int CNT_MAX = FIRST_EDGE_TIMEOUT_US * US_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(RESP_BITS + 1);

  localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] C_SHORT    = CNT_W'(T_SHORT * US_CYCLES);
  localparam logic [CNT_W-1:0] C_LONG     = CNT_W'(T_LONG * US_CYCLES);
  localparam logic [CNT_W-1:0] C_BIT_END  = CNT_W'(T_BIT * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STOP_END = CNT_W'((T_SHORT + 2) * US_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SAMPLE   = CNT_W'(T_SAMPLE * US_CYCLES);
  localparam logic [CNT_W-1:0] C_BIT_TO   = CNT_W'(BIT_TIMEOUT_US * US_CYCLES);
  localparam logic [CNT_W-1:0] C_GUARD    = CNT_W'(T_BIT * US_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(RESP_BITS - 1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0]     hi_cnt, hi_cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [BIT_W-1:0]     rx_cnt, rx_cnt_n;
  logic [RESP_BITS-1:0] shift, shift_n;
  logic                 line_s;
  logic                 fall_s;

  n64_line_sync u_sync (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .line_in (line_in),
    .line_s  (line_s),
    .fall_s  (fall_s)
  );

  // Saturating so a stuck line can never wrap the counter back into a valid window.
  assign cnt_inc = (cnt == C_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_cnt  <= '0;
      bit_idx <= '0;
      rx_cnt  <= '0;
      shift   <= '0;
      buttons <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi_cnt  <= hi_cnt_n;
      bit_idx <= bit_idx_n;
      rx_cnt  <= rx_cnt_n;
      shift   <= shift_n;
      if (state == DONE) buttons <= shift;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt_inc;
    hi_cnt_n    = hi_cnt;
    bit_idx_n   = bit_idx;
    rx_cnt_n    = rx_cnt;
    shift_n     = shift;
    line_oe     = 1'b0;
    resp_valid  = 1'b0;
    timeout_err = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (poll_start) begin
          state_n   = TX_BIT;
          bit_idx_n = 3'd7;
          rx_cnt_n  = '0;
          shift_n   = '0;
        end
      end
      TX_BIT: begin
        line_oe = (cnt < (CMD_BYTE[bit_idx] ? C_SHORT : C_LONG));
        if (cnt == C_BIT_END) begin
          cnt_n = '0;
          if (bit_idx == 3'd0) state_n = TX_STOP;
          else                 bit_idx_n = bit_idx - 3'd1;
        end
      end
      TX_STOP: begin
        line_oe = (cnt < C_SHORT);
        if (cnt == C_STOP_END) begin
          state_n = RX_WAIT;
          cnt_n   = '0;
        end
      end
      RX_WAIT: begin
        if (fall_s) begin
          state_n = RX_BIT;
          cnt_n   = '0;
        end else if (cnt == C_MAX) begin
          timeout_err = 1'b1;
          state_n     = IDLE;
        end
      end
      RX_BIT: begin
        // Any edge restarts the bit timer: before sampling it filters glitches,
        // after sampling it marks the next bit.
        if (fall_s) begin
          cnt_n = '0;
        end else if (cnt == C_SAMPLE) begin
          shift_n  = {shift[RESP_BITS-2:0], line_s};
          rx_cnt_n = rx_cnt + 1'b1;
          if (rx_cnt == LAST_BIT) begin
            state_n = DONE;
            cnt_n   = '0;
          end
        end else if (cnt == C_BIT_TO) begin
          timeout_err = 1'b1;
          state_n     = IDLE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_n    = GUARD;
        cnt_n      = '0;
        hi_cnt_n   = '0;
      end
      GUARD: begin
        hi_cnt_n = line_s ? hi_cnt + 1'b1 : '0;
        if (fall_s) cnt_n = '0;
        if ((line_s && hi_cnt == C_GUARD) || cnt == C_BIT_TO) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign monitor_sig = state;

endmodule

// File: tb/tb_n64_poll_engine.sv
// Self-checking bench for n64_poll_engine with an open-drain controller model.
module tb_n64_poll_engine;

  localparam int US = 100;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        poll_start = 1'b0;
  logic        ctrl_low = 1'b0;
  logic        glitch = 1'b0;
  logic        line_in;
  logic        line_oe;
  logic [31:0] buttons;
  logic        resp_valid;
  logic        timeout_err;
  logic        busy;
  logic [2:0]  monitor_sig;

  int n_checks = 0;
  int n_fail = 0;
  int n_rv = 0;
  int n_to = 0;
  int n_both = 0;
  int cyc = 0;
  logic [31:0] model_buttons = 32'h0;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          glitch_bit;
    int          busy_bit;
    int          delay;
    int          exp_rv;
    int          exp_to;
  } vec_t;

  vec_t vecs[5];

  // Open-drain wire: anyone pulling low wins, pull-up otherwise.
  assign line_in = ~(line_oe | ctrl_low | glitch);

  n64_poll_engine dut (
    .PCLK        (PCLK),
    .PRESETN     (PRESETN),
    .poll_start  (poll_start),
    .line_in     (line_in),
    .line_oe     (line_oe),
    .buttons     (buttons),
    .resp_valid  (resp_valid),
    .timeout_err (timeout_err),
    .busy        (busy),
    .monitor_sig (monitor_sig)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (resp_valid) n_rv++;
    if (timeout_err) n_to++;
    if (resp_valid && timeout_err) n_both++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Expected line_oe for the i-th cycle after poll_start: 0x01 MSB first, then stop bit.
  function automatic logic exp_oe(input int i);
    logic [7:0] cmd;
    int c;
    cmd = 8'h01;
    if (i < 8 * 4 * US) begin
      c = i % (4 * US);
      return c < (cmd[7 - i / (4 * US)] ? US : 3 * US);
    end else if (i < 8 * 4 * US + 3 * US) begin
      return (i - 8 * 4 * US) < US;
    end
    return 1'b0;
  endfunction

  task automatic do_poll(input vec_t v);
    int rv0, to0, errs, t_rx, t_last, t_to;
    logic seen, b;
    rv0 = n_rv;
    to0 = n_to;
    errs = 0;
    t_last = 0;
    t_to = 0;
    @(negedge PCLK) poll_start = 1'b1;
    @(negedge PCLK) poll_start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 8 * 4 * US + 3 * US; i++) begin
      if (line_oe !== exp_oe(i)) errs++;
      @(negedge PCLK);
    end
    check("cmd_waveform_errors", errs, 0);
    check("rx_wait_entry", monitor_sig, 3);
    check("line_released", line_oe, 0);
    t_rx = cyc;

    if (v.nbits > 0) begin
      repeat (v.delay) @(negedge PCLK);
      for (int i = 0; i < v.nbits; i++) begin
        b = v.word[31 - i];
        t_last = cyc;
        for (int c = 0; c < 4 * US; c++) begin
          if (i == v.busy_bit && c == 205) check("busy_ignored_state", monitor_sig, 4);
          ctrl_low   = (c < (b ? US : 3 * US));
          glitch     = (i == v.glitch_bit && c == 150);
          poll_start = (i == v.busy_bit && c == 200);
          @(negedge PCLK);
        end
      end
      ctrl_low = 1'b0;
      glitch = 1'b0;
      poll_start = 1'b0;
    end

    if (v.nbits == 32) begin
      ctrl_low = 1'b1;
      repeat (2 * US) @(negedge PCLK);
      ctrl_low = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 2000 && !seen; k++) begin
        @(negedge PCLK);
        if (monitor_sig == 3'd0) seen = 1'b1;
      end
      check("guard_to_idle", seen, 1);
      model_buttons = v.word;
    end else begin
      seen = 1'b0;
      for (int k = 0; k < 8000 && !seen; k++) begin
        if (timeout_err) begin
          seen = 1'b1;
          t_to = cyc;
        end else begin
          @(negedge PCLK);
        end
      end
      check("timeout_seen", seen, 1);
      if (v.nbits == 0) check("first_edge_timeout_cycles", t_to - t_rx, 6400);
      else check_range("bit_timeout_cycles", t_to - t_last, 800, 806);
      @(negedge PCLK);
      check("idle_after_timeout", monitor_sig, 0);
    end

    repeat (3) @(negedge PCLK);
    check("buttons", buttons, model_buttons);
    check("resp_valid_pulses", n_rv - rv0, v.exp_rv);
    check("timeout_pulses", n_to - to0, v.exp_to);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    vecs[0] = '{32'h8000_7F81, 32, -1, -1, 2 * US, 1, 0};
    vecs[1] = '{32'h0000_0000, 0, -1, -1, 0, 0, 1};
    vecs[2] = '{32'h1234_5678, 17, -1, -1, 2 * US, 0, 1};
    vecs[3] = '{32'hC3A5_5A3C, 32, 6, 10, 2 * US, 1, 0};
    vecs[4] = '{$urandom, 32, -1, -1, int'($urandom_range(100, 3000)), 1, 0};

    repeat (3) @(negedge PCLK);
    check("rst_line_oe", line_oe, 0);
    check("rst_buttons", buttons, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_monitor", monitor_sig, 0);
    PRESETN = 1'b1;
    repeat (2) @(negedge PCLK);

    // Reset in the middle of the third command bit must release the line at once.
    poll_start = 1'b1;
    @(negedge PCLK) poll_start = 1'b0;
    repeat (2 * 4 * US + 50) @(negedge PCLK);
    check("tx_third_bit_driving", line_oe, 1);
    #2 PRESETN = 1'b0;
    #1;
    check("async_rst_line_oe", line_oe, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_monitor", monitor_sig, 0);
    @(negedge PCLK) PRESETN = 1'b1;
    repeat (2) @(negedge PCLK);

    for (int v = 0; v < 5; v++) do_poll(vecs[v]);

    check("valid_timeout_overlap", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n64_poll_engine.md
Name: n64_poll_engine

Overview:
- Protocol engine behind controller_interface on the N64 single-wire data_line.
- On request, it serialises the 1-byte poll command (0x01 plus stop bit) onto the open-drain line.
- It then receives the controller's 32-bit button/joystick response by pulse-width sampling and latches the word for the fabric/MSS.
- The pad-level inout stays in the parent; this block sees a raw line input and a drive-low enable.

Parameters:
US_CYCLES, 100, PCLK cycles per microsecond (FAB_CLK = 100 MHz)
CMD_BYTE, 8'h01, command byte transmitted MSB first
RESP_BITS, 32, response bits captured before completion
FIRST_EDGE_TIMEOUT_US, 64, max wait from end of stop bit to first response falling edge
BIT_TIMEOUT_US, 8, max gap between consecutive response falling edges

Ports:
PCLK  input  1  fabric clock
PRESETN  input  1  asynchronous active-low reset
poll_start  input  1  1-cycle request pulse
line_in  input  1  raw (unsynchronised) data_line level from pad
line_oe  output  1  1 = drive data_line low; 0 = release (pull-up gives high)
buttons  output  32  last good response, bit 31 = first bit received
resp_valid  output  1  1-cycle pulse when buttons updated
timeout_err  output  1  1-cycle pulse on response timeout
busy  output  1  high whenever state != IDLE
monitor_sig  output  3  encoded current state, for scope/LED debug

Behaviour:
- Clock and reset: one clock, PCLK. PRESETN is asynchronous active-low.
- Reset values: line_oe=0, buttons=0, resp_valid=0, timeout_err=0, busy=0, monitor_sig=0 (IDLE). Counters and shift register are cleared.
- Reset asserted mid-transfer releases the line immediately (asynchronously).
- Input synchronisation: line_in passes through a 2-flop synchroniser. A falling edge is a synced 1 followed by synced 0. Latency from pad to edge detection is 2-3 cycles.
- IDLE (0):
  - poll_start goes to TX_BIT, loading bit_idx=7 and cnt=0.
  - poll_start while busy is ignored, with no queuing.
- TX_BIT (1):
  - Each bit occupies 4*US_CYCLES cycles.
  - line_oe=1 for the first 3*US_CYCLES cycles when the bit is 0, or the first 1*US_CYCLES cycles when the bit is 1; line_oe=0 for the remainder.
  - After bit 0 the state moves to TX_STOP.
- TX_STOP (2): line_oe=1 for US_CYCLES cycles, then 0 for 2*US_CYCLES cycles. Then go to RX_WAIT with cnt=0.
- RX_WAIT (3):
  - Line released.
  - A falling edge goes to RX_BIT with cnt=0.
  - cnt reaching FIRST_EDGE_TIMEOUT_US*US_CYCLES pulses timeout_err and returns to IDLE.
- RX_BIT (4):
  - At cnt == 2*US_CYCLES, shift the synced level into the shift register, MSB first: high = 1, low = 0.
  - After sampling, wait for the next falling edge.
  - cnt reaching BIT_TIMEOUT_US*US_CYCLES since the last edge pulses timeout_err and returns to IDLE, with buttons unchanged.
  - After the RESP_BITS-th sample the state moves to DONE; the controller stop bit is not required.
- DONE (5):
  - For one cycle, buttons <= shift register and resp_valid=1.
  - Then go to GUARD.
- GUARD (6):
  - Wait until the line has been continuously high for 4*US_CYCLES cycles, so the controller stop bit is absorbed, then go to IDLE.
  - This state is subject to the BIT_TIMEOUT rule, returning to IDLE without asserting timeout_err.
- Falling edges during TX states are the block's own drive and are ignored.
- A spurious edge before cnt reaches 2*US_CYCLES in RX_BIT restarts cnt; this is a glitch tolerance rule.
- Counter width is clog2(FIRST_EDGE_TIMEOUT_US*US_CYCLES+1). The counter saturates and never wraps.
- resp_valid and timeout_err are never high in the same cycle.
- busy is 1 from the cycle after poll_start through the last GUARD/timeout cycle.

Decomposition:
- Package n64_pkg holds:
  - state enum (IDLE..GUARD with codes 0-6, used directly for monitor_sig);
  - CMD_POLL = 8'h01;
  - bit-time multipliers (T_LONG=3, T_SHORT=1, T_BIT=4, T_SAMPLE=2).
- Sub-module n64_line_sync contains the 2-flop synchroniser plus falling-edge detect, with outputs line_s and fall_s. It is reused by future console/command blocks.

Test Plan:
- Reset mid-TX:
  - Stimulus: PRESETN low during the 3rd command bit.
  - Required: line_oe=0 within the same cycle (asynchronous), busy=0; the next poll_start works normally.
- Command waveform:
  - Stimulus: poll_start, with US_CYCLES=100.
  - Required: seven "0" bits (300 low/100 high cycles each), one "1" bit (100 low/300 high), stop bit (100 low/200 high), then line_oe stays 0.
- Good response:
  - Stimulus: controller model returns 0x8000_7F81 with 1/3 µs timing, 2 µs after the stop bit.
  - Required: buttons=0x80007F81, exactly one resp_valid pulse, timeout_err=0.
- No controller:
  - Stimulus: line held high after the command.
  - Required: timeout_err pulses once 6400 cycles after RX_WAIT entry; buttons keep the previous value; return to IDLE.
- Truncated response:
  - Stimulus: the model stops after 17 bits.
  - Required: timeout_err pulses 800 cycles after the last edge; buttons unchanged; resp_valid never asserted.
- Busy ignore and glitch:
  - Stimulus: poll_start reasserted during RX_BIT, plus a 1-cycle low glitch on line_in.
  - Required: no restart, and the decoded word is still correct because the glitch is filtered by the sync/restart rule.
